stream_handshake_monitor: RTL and testbench
===========================================

Name: stream_handshake_monitor

Overview:
- Passive bench-side observer for a vld/rdy stream, the checking end of the random vld/rdy generators used in benches.
- Sits on any vld/rdy/data interface and counts transfers, stalls and idle cycles.
- Measures per-window transfer and valid occupancy, tracking their minimum and maximum.
- Checks handshake rules and raises `done` after a programmed number of transfers.
- Has no effect on the interface it observes.

Parameters:
- DATA_W, 32: width of the observed data bus.
- WINDOW, 100: measurement window length in clk cycles, at least 2.
- CNT_W, 32: width of the running counters, which saturate.
- WIN_W, 16: width of the window counters; must satisfy 2^WIN_W > WINDOW.

Ports:
- clk  in  1  bench clock; all logic is clocked on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears the counters and arms the monitor.
- expected_count  in  CNT_W  number of transfers until done; 0 means never done. Sampled on start.
- vld  in  1  observed valid.
- rdy  in  1  observed ready.
- data  in  DATA_W  observed data.
- running  out  1  high while the monitor is in the RUN state.
- done  out  1  high while in DONE; stays high until start or rst.
- transfer_count  out  CNT_W  number of vld&rdy cycles since start.
- stall_count  out  CNT_W  number of vld&!rdy cycles.
- idle_count  out  CNT_W  number of !vld cycles.
- win_valid  out  1  one-cycle pulse at the end of each complete window.
- win_xfer  out  WIN_W  transfers in the last completed window.
- win_vld  out  WIN_W  vld-high cycles in the last completed window.
- win_xfer_min  out  WIN_W  minimum win_xfer over completed windows.
- win_xfer_max  out  WIN_W  maximum win_xfer over completed windows.
- err_vld_drop  out  1  sticky: vld fell while a transfer was pending.
- err_data_change  out  1  sticky: data changed while a transfer was pending.

Behaviour:
- Reset: state IDLE.
  - All counters = 0; win_xfer = win_vld = 0; win_xfer_min = all ones; win_xfer_max = 0.
  - running = done = win_valid = 0; both err flags = 0.
  - pending flag and data shadow register cleared.
- FSM, three states:
  - IDLE → RUN on start.
  - RUN → DONE on the cycle where vld&rdy makes transfer_count equal to a nonzero expected_count. The count update and done are visible on the same next edge.
  - DONE → RUN on start.
  - rst from any state → IDLE.
  - start while in RUN restarts: same clear/arm action as from IDLE.
- start action, at the clock edge:
  - Clear the three counters, the window accumulators, min/max and the err flags.
  - Latch expected_count.
  - The bus is not sampled on the start cycle itself; counting begins on the next cycle.
- Counting, only in RUN:
  - Each cycle increments exactly one of transfer/stall/idle, so the three sum to cycles spent in RUN.
  - Counters saturate at all ones and never wrap.
  - Window: phase counter 0..WINDOW-1 with accumulators acc_xfer and acc_vld.
  - At phase WINDOW-1 the accumulated values, including that cycle, are copied to win_xfer/win_vld. win_valid pulses on the next cycle together with the updated outputs.
  - Min/max are updated with the new win_xfer in the same cycle win_valid rises.
  - Accumulators and phase then restart at 0.
  - A partial window at DONE or restart is discarded.
- Protocol check, in RUN and DONE:
  - pending <= vld & !rdy; shadow <= data whenever vld & !rdy.
  - If pending & !vld: set err_vld_drop.
  - If pending & vld & (data != shadow): set err_data_change.
  - Errors are sticky until start or rst.
  - The check is not active in IDLE.
- DONE: counters and window outputs freeze; transfers observed in DONE are ignored.
- expected_count = 0: stays in RUN until rst or start.

Decomposition:
- Package stream_mon_pkg holds:
  - typedef mon_state_e {IDLE, RUN, DONE};
  - a saturating-increment function, parametrised by width through a packed vector argument.
- One natural sub-module: stream_window_rate, holding the phase counter, accumulators, snapshot and min/max, with inputs clk, rst, clear, enable, xfer, vld.
- The top level keeps the FSM, the running counters and the protocol checker.

Test Plan:
- rst, start with expected_count=5, vld=rdy=1 constantly → transfer_count=1..5 on consecutive cycles; done=1 on the edge where the count reaches 5; stall=idle=0; no errors.
- WINDOW=100, expected_count=0, vld=1, rdy toggles 1/0 each cycle:
  - win_valid pulses every 100 cycles with win_xfer=50 and win_vld=100;
  - min=max=50;
  - stall_count=50 after the first window.
- vld=1, rdy=0 for 3 cycles with data held at 0xA5, then vld drops → err_vld_drop=1 the next cycle and stays set; err_data_change=0.
- vld=1, rdy=0, data changes 0x11→0x22 while stalled → err_data_change=1; a subsequent start clears it to 0.
- Mid-RUN rst after 7 transfers → next cycle all outputs at reset values, running=0; traffic without start leaves counts at 0.
- CNT_W=4, expected_count=0, 20 transfers → transfer_count saturates at 15; windows with alternating 30 and 70 transfers → min=30, max=70.

Source files
------------

// File: rtl/stream_mon_pkg.sv
// Shared types and helpers for the stream handshake monitor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   mon_state_e : monitor FSM states
//   SAT_MAX_W   : widest counter the saturating helper supports
//   sat_inc     : saturating increment; the counter width is given by an
//                 all-ones mask vector so one function serves every width
package stream_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mon_state_e;

  localparam int SAT_MAX_W = 64;

  // value and all_ones are zero-extended copies of a narrower counter.
  // all_ones carries the counter's own maximum, so the increment stops there
  // instead of at the full 64-bit limit.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] value,
    input logic [SAT_MAX_W-1:0] all_ones
  );
    logic [SAT_MAX_W-1:0] result;
    result = (value == all_ones) ? value : value + SAT_MAX_W'(1);
    return result;
  endfunction

endpackage

// File: rtl/stream_window_rate.sv
// Per-window transfer / valid occupancy meter with running min/max.
// Latency: snapshot and win_valid appear one clock after the last window cycle.
// Backpressure: none; purely observes the xfer/vld strobes it is given.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clear           : restart measurement; drops partial window and min/max
//   enable          : count this cycle (monitor is in RUN)
//   xfer, vld       : this cycle's transfer and valid strobes
//   win_valid       : one-cycle pulse when a completed window is published
//   win_xfer/win_vld: totals of the last completed window
//   win_xfer_min/max: extremes of win_xfer over completed windows
module stream_window_rate
  import stream_mon_pkg::*;
#(
  parameter int WINDOW = 100,
  parameter int WIN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             xfer,
  input  logic             vld,
  output logic             win_valid,
  output logic [WIN_W-1:0] win_xfer,
  output logic [WIN_W-1:0] win_vld,
  output logic [WIN_W-1:0] win_xfer_min,
  output logic [WIN_W-1:0] win_xfer_max
);

  localparam logic [WIN_W-1:0] LAST_PHASE = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] phase;
  logic [WIN_W-1:0] acc_xfer;
  logic [WIN_W-1:0] acc_vld;
  logic [WIN_W-1:0] xfer_total;
  logic [WIN_W-1:0] vld_total;
  logic             window_end;

  // Totals including the current cycle; these are what gets published when
  // the current cycle closes the window.
  assign xfer_total = acc_xfer + WIN_W'(xfer);
  assign vld_total  = acc_vld + WIN_W'(vld);
  assign window_end = enable && (phase == LAST_PHASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      acc_xfer     <= '0;
      acc_vld      <= '0;
      win_valid    <= 1'b0;
      win_xfer     <= '0;
      win_vld      <= '0;
      win_xfer_min <= '1;
      win_xfer_max <= '0;
    end else if (clear) begin
      // Published window values are kept; only the measurement restarts.
      phase        <= '0;
      acc_xfer     <= '0;
      acc_vld      <= '0;
      win_valid    <= 1'b0;
      win_xfer_min <= '1;
      win_xfer_max <= '0;
    end else begin
      win_valid <= window_end;
      if (window_end) begin
        phase    <= '0;
        acc_xfer <= '0;
        acc_vld  <= '0;
        win_xfer <= xfer_total;
        win_vld  <= vld_total;
        // Compared against the fresh total so min/max move with win_valid.
        if (xfer_total < win_xfer_min) win_xfer_min <= xfer_total;
        if (xfer_total > win_xfer_max) win_xfer_max <= xfer_total;
      end else if (enable) begin
        phase    <= phase + WIN_W'(1);
        acc_xfer <= xfer_total;
        acc_vld  <= vld_total;
      end
    end
  end

endmodule

// File: rtl/stream_handshake_monitor.sv
// Passive vld/rdy stream observer: counts transfers/stalls/idles, measures
// window occupancy, checks handshake rules, flags done after N transfers.
// Latency: all outputs are registered, updated one clock after the observed cycle.
// Backpressure: none; never drives the observed interface.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : pulse; clears counters/errors, latches expected_count
//   expected_count       : transfers until done (0 = never)
//   vld, rdy, data       : observed stream
//   running, done        : FSM in RUN / DONE
//   transfer/stall/idle_count : saturating cycle classification counters
//   win_*                : window occupancy results (see stream_window_rate)
//   err_vld_drop         : sticky, vld withdrawn while a stalled beat was pending
//   err_data_change      : sticky, data altered while a stalled beat was pending
module stream_handshake_monitor
  import stream_mon_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WINDOW = 100,
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  expected_count,
  input  logic              vld,
  input  logic              rdy,
  input  logic [DATA_W-1:0] data,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  transfer_count,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  idle_count,
  output logic              win_valid,
  output logic [WIN_W-1:0]  win_xfer,
  output logic [WIN_W-1:0]  win_vld,
  output logic [WIN_W-1:0]  win_xfer_min,
  output logic [WIN_W-1:0]  win_xfer_max,
  output logic              err_vld_drop,
  output logic              err_data_change
);

  localparam logic [SAT_MAX_W-1:0] CNT_ONES = SAT_MAX_W'({CNT_W{1'b1}});

  mon_state_e state;
  mon_state_e state_nxt;

  logic [CNT_W-1:0]     exp_q;
  logic                 pending;
  logic [DATA_W-1:0]    shadow;

  logic [SAT_MAX_W-1:0] xfer_inc_w;
  logic [SAT_MAX_W-1:0] stall_inc_w;
  logic [SAT_MAX_W-1:0] idle_inc_w;
  logic [CNT_W-1:0]     xfer_next;
  logic [CNT_W-1:0]     stall_next;
  logic [CNT_W-1:0]     idle_next;
  logic                 unused_sat_bits;

  logic                 xfer;
  logic                 count_en;
  logic                 hit;

  // ---------------------------------------------------------------------------
  // Saturating next values for the running counters
  // ---------------------------------------------------------------------------
  assign xfer_inc_w  = sat_inc(SAT_MAX_W'(transfer_count), CNT_ONES);
  assign stall_inc_w = sat_inc(SAT_MAX_W'(stall_count), CNT_ONES);
  assign idle_inc_w  = sat_inc(SAT_MAX_W'(idle_count), CNT_ONES);
  assign xfer_next   = xfer_inc_w[CNT_W-1:0];
  assign stall_next  = stall_inc_w[CNT_W-1:0];
  assign idle_next   = idle_inc_w[CNT_W-1:0];
  // Upper bits of the widened results are always zero and intentionally dropped.
  assign unused_sat_bits = ^{xfer_inc_w, stall_inc_w, idle_inc_w};

  assign xfer     = vld & rdy;
  // The start cycle itself is never sampled, even when restarting from RUN.
  assign count_en = (state == RUN) && !start;
  // Done is reached by the transfer that makes the count equal a nonzero target.
  assign hit      = count_en && xfer && (exp_q != '0) && (xfer_next == exp_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (start) state_nxt = RUN;
               else if (hit) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    unique case (state)
      RUN:     running = 1'b1;
      DONE:    done    = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Running counters: exactly one of the three advances per RUN cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      transfer_count <= '0;
      stall_count    <= '0;
      idle_count     <= '0;
      exp_q          <= '0;
    end else if (start) begin
      transfer_count <= '0;
      stall_count    <= '0;
      idle_count     <= '0;
      exp_q          <= expected_count;
    end else if (count_en) begin
      if (xfer) begin
        transfer_count <= xfer_next;
      end else if (vld) begin
        stall_count <= stall_next;
      end else begin
        idle_count <= idle_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake rule checker, live in RUN and DONE
  // ---------------------------------------------------------------------------
  // A beat offered but not taken (vld & !rdy) must be re-offered unchanged on
  // the following cycle. shadow holds the offered data for that comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending         <= 1'b0;
      shadow          <= '0;
      err_vld_drop    <= 1'b0;
      err_data_change <= 1'b0;
    end else if (start) begin
      pending         <= 1'b0;
      shadow          <= '0;
      err_vld_drop    <= 1'b0;
      err_data_change <= 1'b0;
    end else if (state != IDLE) begin
      pending <= vld & ~rdy;
      if (vld & ~rdy) shadow <= data;
      if (pending & ~vld) err_vld_drop <= 1'b1;
      if (pending & vld & (data != shadow)) err_data_change <= 1'b1;
    end else begin
      pending <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Window occupancy meter
  // ---------------------------------------------------------------------------
  stream_window_rate #(
    .WINDOW (WINDOW),
    .WIN_W  (WIN_W)
  ) u_window (
    .clk          (clk),
    .rst          (rst),
    .clear        (start),
    .enable       (count_en),
    .xfer         (xfer),
    .vld          (vld),
    .win_valid    (win_valid),
    .win_xfer     (win_xfer),
    .win_vld      (win_vld),
    .win_xfer_min (win_xfer_min),
    .win_xfer_max (win_xfer_max)
  );

endmodule

// File: tb/tb_stream_handshake_monitor.sv
// Self-checking bench for stream_handshake_monitor with a scoreboard for
// completed windows and a behavioural model for counters, FSM and errors.
module tb_stream_handshake_monitor;

  localparam int DATA_W  = 32;
  localparam int WINDOW  = 100;
  localparam int CNT_W   = 32;
  localparam int WIN_W   = 16;
  localparam int SMALL_W = 4;

  logic clk = 1'b0;
  logic rst, start, vld, rdy;
  logic [DATA_W-1:0]  data;
  logic [CNT_W-1:0]   expected_count;
  logic [SMALL_W-1:0] exp_small;

  logic running, done, win_valid, err_vld_drop, err_data_change;
  logic [CNT_W-1:0] transfer_count, stall_count, idle_count;
  logic [WIN_W-1:0] win_xfer, win_vld, win_xfer_min, win_xfer_max;

  logic s_running, s_done, s_win_valid, s_err_vld_drop, s_err_data_change;
  logic [SMALL_W-1:0] s_transfer_count, s_stall_count, s_idle_count;
  logic [WIN_W-1:0] s_win_xfer, s_win_vld, s_win_xfer_min, s_win_xfer_max;

  always #5 clk = ~clk;

  stream_handshake_monitor #(.DATA_W(DATA_W), .WINDOW(WINDOW), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .expected_count(expected_count),
    .vld(vld), .rdy(rdy), .data(data), .running(running), .done(done),
    .transfer_count(transfer_count), .stall_count(stall_count), .idle_count(idle_count),
    .win_valid(win_valid), .win_xfer(win_xfer), .win_vld(win_vld),
    .win_xfer_min(win_xfer_min), .win_xfer_max(win_xfer_max),
    .err_vld_drop(err_vld_drop), .err_data_change(err_data_change));

  stream_handshake_monitor #(.DATA_W(DATA_W), .WINDOW(WINDOW), .CNT_W(SMALL_W), .WIN_W(WIN_W)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .expected_count(exp_small),
    .vld(vld), .rdy(rdy), .data(data), .running(s_running), .done(s_done),
    .transfer_count(s_transfer_count), .stall_count(s_stall_count), .idle_count(s_idle_count),
    .win_valid(s_win_valid), .win_xfer(s_win_xfer), .win_vld(s_win_vld),
    .win_xfer_min(s_win_xfer_min), .win_xfer_max(s_win_xfer_max),
    .err_vld_drop(s_err_vld_drop), .err_data_change(s_err_data_change));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_small = 1'b0;

  typedef struct { int xfer; int vld; int mn; int mx; int cyc; } win_t;
  win_t win_q[$];
  win_t mon_w;

  // Reference model: plain counts since the last start.
  int          m_state;   // 0 idle, 1 run, 2 done
  longint      m_tc, m_sc, m_ic, m_exp;
  bit          m_drop, m_dchg, m_pend;
  logic [31:0] m_shadow;
  int          m_cycles, m_wx, m_wv, m_min, m_max;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic longint sat(input longint x, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_clear();
    m_tc = 0; m_sc = 0; m_ic = 0;
    m_drop = 0; m_dchg = 0; m_pend = 0; m_shadow = '0;
    m_cycles = 0; m_wx = 0; m_wv = 0; m_min = 65535; m_max = 0;
  endtask

  task automatic model_step(input bit v, input bit r, input logic [31:0] d,
                            input bit s, input logic [31:0] e, input bit rs);
    if (rs) begin
      model_clear(); m_state = 0; m_exp = 0;
    end else if (s) begin
      model_clear(); m_state = 1; m_exp = e;
    end else begin
      if (m_state != 0) begin
        if (m_pend && !v) m_drop = 1;
        if (m_pend && v && d != m_shadow) m_dchg = 1;
        if (v && !r) m_shadow = d;
        m_pend = v && !r;
      end else begin
        m_pend = 0;
      end
      if (m_state == 1) begin
        if (v && r) m_tc++; else if (v) m_sc++; else m_ic++;
        m_wx += (v && r) ? 1 : 0;
        m_wv += v ? 1 : 0;
        m_cycles++;
        if (m_cycles % WINDOW == 0) begin
          if (m_wx < m_min) m_min = m_wx;
          if (m_wx > m_max) m_max = m_wx;
          win_q.push_back('{m_wx, m_wv, m_min, m_max, cyc + 1});
          m_wx = 0; m_wv = 0;
        end
        if (m_exp != 0 && v && r && sat(m_tc, CNT_W) == m_exp) m_state = 2;
      end
    end
  endtask

  task automatic check_main();
    check("running", running, (m_state == 1) ? 1 : 0);
    check("done", done, (m_state == 2) ? 1 : 0);
    check("transfer_count", transfer_count, sat(m_tc, CNT_W));
    check("stall_count", stall_count, sat(m_sc, CNT_W));
    check("idle_count", idle_count, sat(m_ic, CNT_W));
    check("err_vld_drop", err_vld_drop, m_drop);
    check("err_data_change", err_data_change, m_dchg);
    if (chk_small) check("sat_transfer_count", s_transfer_count, sat(m_tc, SMALL_W));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win_xfer"}, win_xfer, 0);
    check({tag, "_win_vld"}, win_vld, 0);
    check({tag, "_win_min"}, win_xfer_min, 16'hFFFF);
    check({tag, "_win_max"}, win_xfer_max, 0);
  endtask

  task automatic drive_cycle(input bit v, input bit r, input logic [31:0] d,
                             input bit s, input logic [31:0] e, input bit rs);
    vld = v; rdy = r; data = d; start = s; expected_count = e; rst = rs;
    model_step(v, r, d, s, e, rs);
    @(posedge clk);
    cyc++;
    #1;
    start = 1'b0; rst = 1'b0;
    check_main();
  endtask

  // Scoreboard monitor: compares each published window against the queue.
  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      if (win_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL win_unexpected: win_valid=1 with no expected window (cycle %0d)", cyc);
      end else begin
        mon_w = win_q.pop_front();
        check("win_cycle", cyc, mon_w.cyc);
        check("win_xfer", win_xfer, mon_w.xfer);
        check("win_vld", win_vld, mon_w.vld);
        check("win_xfer_min", win_xfer_min, mon_w.mn);
        check("win_xfer_max", win_xfer_max, mon_w.mx);
      end
    end
  end

  initial begin
    exp_small = '0;
    vld = 0; rdy = 0; data = '0; start = 0; expected_count = '0; rst = 1;

    // Reset
    drive_cycle(0, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    check_reset_outputs("reset");

    // Count to 5 with vld=rdy=1, then freeze in DONE
    drive_cycle(1, 1, 32'h1, 1, 5, 0);
    for (int i = 1; i <= 5; i++) begin
      drive_cycle(1, 1, 32'(i), 0, 5, 0);
      check("t1_xfer_step", transfer_count, i);
    end
    check("t1_done", done, 1);
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 32'h9, 0, 5, 0);
    check("t1_frozen", transfer_count, 5);

    // Alternating ready: 50 transfers / 100 valid per window
    drive_cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 250; i++) begin
      drive_cycle(1, (i % 2) == 0, 32'h0, 0, 0, 0);
      if (i == 99) check("t2_stall_after_win", stall_count, 50);
    end
    check("t2_min", win_xfer_min, 50);
    check("t2_max", win_xfer_max, 50);

    // Valid withdrawn while stalled
    drive_cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 32'hA5, 0, 0, 0);
    drive_cycle(0, 0, 32'hA5, 0, 0, 0);
    check("t3_drop", err_vld_drop, 1);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 32'h0, 0, 0, 0);
    check("t3_drop_sticky", err_vld_drop, 1);
    check("t3_no_dchg", err_data_change, 0);

    // Data changed while stalled, then cleared by start
    drive_cycle(0, 0, 0, 1, 0, 0);
    drive_cycle(1, 0, 32'h11, 0, 0, 0);
    drive_cycle(1, 0, 32'h22, 0, 0, 0);
    check("t4_dchg", err_data_change, 1);
    drive_cycle(1, 1, 32'h22, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 0, 0);
    check("t4_dchg_cleared", err_data_change, 0);

    // Mid-run reset after 7 transfers
    for (int i = 0; i < 7; i++) drive_cycle(1, 1, 32'(i), 0, 0, 0);
    check("t5_seven", transfer_count, 7);
    drive_cycle(1, 1, 0, 0, 0, 1);
    check("t5_running", running, 0);
    check("t5_count", transfer_count, 0);
    check_reset_outputs("t5");
    for (int i = 0; i < 10; i++) drive_cycle(1, 1, 32'(i), 0, 0, 0);
    check("t5_idle_count", transfer_count, 0);

    // Saturation on the 4-bit instance; windows alternate 30/70 transfers
    chk_small = 1'b1;
    drive_cycle(0, 0, 0, 1, 0, 0);
    for (int w = 0; w < 4; w++) begin
      int need;
      need = (w % 2 == 0) ? 30 : 70;
      for (int left = WINDOW; left > 0; left--) begin
        bit x, v, r;
        x = (need > 0) && ((need >= left) || ($urandom_range(0, left - 1) < need));
        if (x) begin
          v = 1; r = 1; need--;
        end else begin
          v = $urandom_range(0, 1); r = v ? 1'b0 : 1'($urandom_range(0, 1));
        end
        drive_cycle(v, r, $urandom, 0, 0, 0);
      end
    end
    check("sat_count", s_transfer_count, 15);
    check("sat_min", s_win_xfer_min, 30);
    check("sat_max", s_win_xfer_max, 70);
    chk_small = 1'b0;

    // Randomised traffic with occasional restart / reset
    for (int round = 0; round < 8; round++) begin
      bit pv, pr;
      logic [31:0] pd;
      int n;
      pv = 0; pr = 0; pd = '0;
      drive_cycle(0, 0, 0, 1, $urandom_range(0, 40), 0);
      n = $urandom_range(80, 260);
      for (int i = 0; i < n; i++) begin
        bit v, r, s, rs;
        logic [31:0] d;
        if (pv && !pr && $urandom_range(0, 9) < 8) begin
          v = 1; d = pd;
        end else begin
          v = ($urandom_range(0, 9) < 7); d = $urandom_range(0, 15);
        end
        r  = ($urandom_range(0, 9) < 6);
        s  = ($urandom_range(0, 199) == 0);
        rs = ($urandom_range(0, 299) == 0);
        drive_cycle(v, r, d, s, $urandom_range(0, 40), rs);
        pv = v; pr = r; pd = d;
      end
    end

    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, 0);
    check("win_queue_drained", win_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
